// File: rtl/reg_writeback.sv
// Writeback stage: accepts one retiring instruction per handshake, waits for load data when
// needed, and issues exactly one register-file write / branch pulse (or a timeout error) per instruction.
module reg_writeback #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_we,
  input  logic [3:0]  in_wa,
  input  logic [31:0] in_alu,
  input  logic        in_is_load,
  input  logic        in_is_byte,
  input  logic [1:0]  in_byte_sel,
  input  logic        in_is_branch,
  input  logic [31:0] in_target,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        we,
  output logic [3:0]  wa,
  output logic [31:0] wd,
  output logic        ib,
  output logic [31:0] bv,
  output logic        err
);

  // state    | meaning
  // IDLE     | ready to accept an instruction
  // WAIT_MEM | load accepted, waiting for mem_rvalid or timeout
  // COMMIT   | write/branch pulse is on the outputs this cycle
  typedef enum logic [1:0] {IDLE, WAIT_MEM, COMMIT} state_t;

  localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;

  logic          lat_we, lat_is_byte, lat_is_branch;
  logic [3:0]    lat_wa;
  logic [1:0]    lat_byte_sel;
  logic [31:0]   lat_target;

  logic          xfer, mem_hit, tmo;
  logic [31:0]   load_data;
  logic          we_d, ib_d, err_d;
  logic [3:0]    wa_d;
  logic [31:0]   wd_d, bv_d;

  assign xfer    = in_valid & in_ready;
  assign mem_hit = (state == WAIT_MEM) & mem_rvalid;
  // rvalid on the last allowed cycle takes priority over the timeout
  assign tmo     = (state == WAIT_MEM) & ~mem_rvalid & (cnt == CNT_LAST);
  assign load_data = lat_is_byte ? {24'b0, mem_rdata[{lat_byte_sel, 3'b000} +: 8]} : mem_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (xfer) state_nxt = in_is_load ? WAIT_MEM : COMMIT;
      WAIT_MEM: if (mem_rvalid) state_nxt = COMMIT;
                else if (tmo)   state_nxt = IDLE;
      COMMIT:   state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == IDLE);
    we_d  = 1'b0;
    ib_d  = 1'b0;
    err_d = 1'b0;
    wa_d  = wa;
    wd_d  = wd;
    bv_d  = bv;
    if (xfer && !in_is_load) begin
      we_d = in_we & ~(in_is_branch & (in_wa == 4'hf));
      ib_d = in_is_branch;
      wa_d = in_wa;
      wd_d = in_alu;
      if (in_is_branch) bv_d = in_target;
    end else if (mem_hit) begin
      we_d = lat_we & ~(lat_is_branch & (lat_wa == 4'hf));
      ib_d = lat_is_branch;
      wa_d = lat_wa;
      wd_d = load_data;
      if (lat_is_branch) bv_d = lat_target;
    end else if (tmo) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt           <= '0;
      lat_we        <= 1'b0;
      lat_wa        <= 4'h0;
      lat_is_byte   <= 1'b0;
      lat_byte_sel  <= 2'b00;
      lat_is_branch <= 1'b0;
      lat_target    <= 32'h0;
      we            <= 1'b0;
      ib            <= 1'b0;
      err           <= 1'b0;
      wa            <= 4'h0;
      wd            <= 32'h0;
      bv            <= 32'h0;
    end else begin
      if (xfer) begin
        cnt           <= '0;
        lat_we        <= in_we;
        lat_wa        <= in_wa;
        lat_is_byte   <= in_is_byte;
        lat_byte_sel  <= in_byte_sel;
        lat_is_branch <= in_is_branch;
        lat_target    <= in_target;
      end else if (state == WAIT_MEM && !mem_rvalid) begin
        cnt <= cnt + 1'b1;
      end
      we  <= we_d;
      ib  <= ib_d;
      err <= err_d;
      wa  <= wa_d;
      wd  <= wd_d;
      bv  <= bv_d;
    end
  end

endmodule

// File: tb/tb_reg_writeback.sv
// Self-checking bench for reg_writeback: table of instructions plus scoreboard of expected
// pulses, with hand-written sequences for exact timing, timeout and mid-operation reset.
module tb_reg_writeback;

  localparam int T = 16;

  logic        clk, rst;
  logic        in_valid, in_ready, in_we, in_is_load, in_is_byte, in_is_branch;
  logic [3:0]  in_wa;
  logic [31:0] in_alu, in_target;
  logic [1:0]  in_byte_sel;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        we, ib, err;
  logic [3:0]  wa;
  logic [31:0] wd, bv;

  reg_writeback #(.MEM_TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_we(in_we), .in_wa(in_wa), .in_alu(in_alu), .in_is_load(in_is_load),
    .in_is_byte(in_is_byte), .in_byte_sel(in_byte_sel), .in_is_branch(in_is_branch),
    .in_target(in_target), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .we(we), .wa(wa), .wd(wd), .ib(ib), .bv(bv), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [3:0]  wa;
    logic [31:0] alu;
    logic        ld;
    logic        byt;
    logic [1:0]  sel;
    logic        br;
    logic [31:0] tgt;
    int          lat;
    logic [31:0] rdata;
  } vec_t;

  typedef struct {
    logic        we;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic        ib;
    logic [31:0] bv;
    logic        err;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [3:0]  last_wa = 4'h0;
  logic [31:0] last_wd = 32'h0;
  logic        prev_pulse = 1'b0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic exp_t model(vec_t v);
    exp_t e;
    logic [31:0] r;
    r = v.rdata;
    e.err = v.ld && (v.lat >= T);
    e.we  = !e.err && v.we && !(v.br && v.wa == 4'd15);
    e.ib  = !e.err && v.br;
    e.wa  = v.wa;
    e.bv  = v.tgt;
    if (!v.ld)      e.wd = v.alu;
    else if (v.byt) case (v.sel)
                      2'd0: e.wd = {24'b0, r[7:0]};
                      2'd1: e.wd = {24'b0, r[15:8]};
                      2'd2: e.wd = {24'b0, r[23:16]};
                      default: e.wd = {24'b0, r[31:24]};
                    endcase
    else            e.wd = r;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      prev_pulse <= 1'b0;
    end else begin
      if (we || ib || err) begin
        n_cmp++;
        if (prev_pulse) begin
          n_bad++;
          $display("FAIL pulse_width: pulse high two cycles we=%b ib=%b err=%b", we, ib, err);
        end
        if (q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_pulse: got we=%b ib=%b err=%b expected none", we, ib, err);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("we", {31'b0, we}, {31'b0, e.we});
          chk("ib", {31'b0, ib}, {31'b0, e.ib});
          chk("err", {31'b0, err}, {31'b0, e.err});
          if (!e.err) begin
            chk("wa", {28'b0, wa}, {28'b0, e.wa});
            chk("wd", wd, e.wd);
          end
          if (e.ib) chk("bv", bv, e.bv);
        end
      end
      prev_pulse <= we || ib || err;
    end
  end

  task automatic drive_accept(vec_t v, logic rv_in_accept);
    exp_t e;
    int   n;
    n = 0;
    while (!in_ready && n < 60) begin @(posedge clk); #1; n++; end
    if (!in_ready) begin n_cmp++; n_bad++; $display("FAIL ready_timeout: in_ready 0 expected 1"); end
    in_we = v.we; in_wa = v.wa; in_alu = v.alu; in_is_load = v.ld; in_is_byte = v.byt;
    in_byte_sel = v.sel; in_is_branch = v.br; in_target = v.tgt; in_valid = 1'b1;
    if (rv_in_accept) begin mem_rvalid = 1'b1; mem_rdata = 32'hBADBAD00; end
    e = model(v);
    if (e.we || e.ib || e.err) q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0; mem_rvalid = 1'b0;
    in_alu = 32'hFFFF_FFFF; in_target = 32'hFFFF_FFFF; in_wa = 4'hA;
  endtask

  task automatic drain(vec_t v);
    exp_t e;
    int   n;
    e = model(v);
    n = 0;
    while (!(in_ready && q.size() == 0) && n < 60) begin @(posedge clk); #1; n++; end
    if (n >= 60) begin n_cmp++; n_bad++; $display("FAIL drain_timeout: queue %0d expected 0", q.size()); end
    if (!e.err) begin last_wa = e.wa; last_wd = e.wd; end
    chk("wa_hold", {28'b0, wa}, {28'b0, last_wa});
    chk("wd_hold", wd, last_wd);
  endtask

  task automatic send(vec_t v);
    drive_accept(v, 1'b0);
    if (v.ld && v.lat < T) begin
      repeat (v.lat) begin @(posedge clk); #1; end
      mem_rvalid = 1'b1; mem_rdata = v.rdata;
      @(posedge clk); #1;
      mem_rvalid = 1'b0; mem_rdata = 32'h0;
    end
    drain(v);
  endtask

  vec_t tbl[12];
  vec_t v;
  int   k;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_we = 1'b0; in_wa = 4'h0; in_alu = 32'h0;
    in_is_load = 1'b0; in_is_byte = 1'b0; in_byte_sel = 2'b00; in_is_branch = 1'b0;
    in_target = 32'h0; mem_rvalid = 1'b0; mem_rdata = 32'h0;

    //            we  wa     alu           ld  byt sel br  tgt           lat    rdata
    tbl[0]  = '{1'b1, 4'd3,  32'hDEADBEEF, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0,     0,     32'h0};
    tbl[1]  = '{1'b1, 4'd5,  32'h0,        1'b1, 1'b1, 2'd2, 1'b0, 32'h0,     3,     32'h11223344};
    tbl[2]  = '{1'b1, 4'd15, 32'h0,        1'b0, 1'b0, 2'd0, 1'b1, 32'h100,   0,     32'h0};
    tbl[3]  = '{1'b1, 4'd14, 32'h40,       1'b0, 1'b0, 2'd0, 1'b1, 32'h200,   0,     32'h0};
    tbl[4]  = '{1'b1, 4'd7,  32'h0,        1'b1, 1'b0, 2'd3, 1'b0, 32'h0,     0,     32'hCAFEF00D};
    tbl[5]  = '{1'b1, 4'd1,  32'h0,        1'b1, 1'b1, 2'd0, 1'b0, 32'h0,     1,     32'h11223344};
    tbl[6]  = '{1'b1, 4'd2,  32'h0,        1'b1, 1'b1, 2'd3, 1'b0, 32'h0,     5,     32'h99887766};
    tbl[7]  = '{1'b0, 4'd9,  32'h55,       1'b0, 1'b0, 2'd0, 1'b0, 32'h0,     0,     32'h0};
    tbl[8]  = '{1'b1, 4'd2,  32'h0,        1'b1, 1'b0, 2'd0, 1'b1, 32'h300,   2,     32'h12345678};
    tbl[9]  = '{1'b1, 4'd4,  32'h0,        1'b1, 1'b0, 2'd0, 1'b0, 32'h0,     T - 1, 32'hAABBCCDD};
    tbl[10] = '{1'b1, 4'd6,  32'h12345678, 1'b0, 1'b1, 2'd1, 1'b0, 32'h0,     0,     32'h0};
    tbl[11] = '{1'b0, 4'd11, 32'h77,       1'b0, 1'b0, 2'd0, 1'b1, 32'h400,   0,     32'h0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_we", {31'b0, we}, 32'd0);
    chk("rst_ib", {31'b0, ib}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_wa", {28'b0, wa}, 32'd0);
    chk("rst_wd", wd, 32'd0);
    chk("rst_bv", bv, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // exact commit timing for an ALU op
    drive_accept(tbl[0], 1'b0);
    chk("alu_c1_we", {31'b0, we}, 32'd1);
    chk("alu_c1_ready", {31'b0, in_ready}, 32'd0);
    chk("alu_c1_wd", wd, 32'hDEADBEEF);
    @(posedge clk); #1;
    chk("alu_c2_we", {31'b0, we}, 32'd0);
    chk("alu_c2_ready", {31'b0, in_ready}, 32'd1);
    drain(tbl[0]);

    for (int i = 0; i < 12; i++) send(tbl[i]);

    // timeout arrives exactly T cycles after entering WAIT_MEM (accept is cycle 0)
    v = '{1'b1, 4'd12, 32'h0, 1'b1, 1'b0, 2'd0, 1'b0, 32'h0, T, 32'h0};
    drive_accept(v, 1'b0);
    k = 1;
    while (!err && k < 40) begin @(negedge clk); if (!err) k++; end
    chk("tmo_cycle", k, T + 1);
    chk("tmo_no_we", {31'b0, we}, 32'd0);
    drain(v);

    // stray rvalid in IDLE and in the accept cycle must be ignored
    mem_rvalid = 1'b1; mem_rdata = 32'h0BAD0BAD;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    v = '{1'b1, 4'd8, 32'h0, 1'b1, 1'b0, 2'd0, 1'b0, 32'h0, 2, 32'h0000A5A5};
    drive_accept(v, 1'b1);
    repeat (2) begin @(posedge clk); #1; end
    mem_rvalid = 1'b1; mem_rdata = 32'h0000A5A5;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    drain(v);

    // reset while waiting for memory discards the load
    v = '{1'b1, 4'd10, 32'h0, 1'b1, 1'b0, 2'd0, 1'b1, 32'h500, 2, 32'h1};
    drive_accept(v, 1'b0);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_mid_wa", {28'b0, wa}, 32'd0);
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h12121212;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    chk("rst_after_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_after_wd", wd, 32'd0);
    chk("final_queue", q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
